// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory bus, decode handshake and ALU redirect of the fetch stage.
interface fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_ready;
  logic        jump_occured;
  logic [15:0] jump_target;
  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_rdata, if_ready, jump_occured, jump_target
  );
  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_rdata, if_ready, jump_occured, jump_target
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, word-addressed imem requests and a prefetch queue feeding decode with redirect flush.
// Defining FETCH_PERF_CNT_EN adds saturating perf_fetched/perf_flushed counter outputs.
module fetch_stage #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]   perf_fetched,
  output logic [15:0]   perf_flushed
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [15:0] pc_q, pc_d, inflight_addr_q, inflight_addr_d;
  logic [AW-1:0] rp_q, rp_d, wp_q, wp_d;
  logic [AW:0] count_q, count_d;
  logic inflight_q, inflight_d, squash_q, squash_d;
  logic [15:0] instr_q [DEPTH];
  logic [15:0] instr_d [DEPTH];
  logic [15:0] ipc_q [DEPTH];
  logic [15:0] ipc_d [DEPTH];
  logic jump, issue, push, pop, valid;
  // The in-flight word holds a reserved slot, so the queue can never overflow.
  always_comb begin
    jump = bus.jump_occured;
    issue = rst_n && !jump && ((count_q + (AW+1)'(inflight_q)) < (AW+1)'(DEPTH));
    push = inflight_q && !squash_q && !jump;
    valid = (count_q != '0) && !jump;
    pop = valid && bus.if_ready;
    pc_d = jump ? bus.jump_target : issue ? pc_q + 16'd1 : pc_q;
    inflight_d = issue;
    inflight_addr_d = issue ? pc_q : inflight_addr_q;
    squash_d = jump && inflight_q;
    rp_d = jump ? '0 : rp_q + AW'(pop);
    wp_d = jump ? '0 : wp_q + AW'(push);
    count_d = jump ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    instr_d = instr_q;
    ipc_d = ipc_q;
    if (push) begin
      instr_d[wp_q] = bus.imem_rdata;
      ipc_d[wp_q] = inflight_addr_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      inflight_addr_q <= '0;
      rp_q <= '0;
      wp_q <= '0;
      count_q <= '0;
      inflight_q <= 1'b0;
      squash_q <= 1'b0;
      instr_q <= '{default: '0};
      ipc_q <= '{default: '0};
    end else begin
      pc_q <= pc_d;
      inflight_addr_q <= inflight_addr_d;
      rp_q <= rp_d;
      wp_q <= wp_d;
      count_q <= count_d;
      inflight_q <= inflight_d;
      squash_q <= squash_d;
      instr_q <= instr_d;
      ipc_q <= ipc_d;
    end
  end
  assign bus.imem_req = issue;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid = valid;
  assign bus.if_instr = instr_q[rp_q];
  assign bus.if_pc = ipc_q[rp_q];
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetched_q, fetched_d, flushed_q, flushed_d;
  logic [16:0] flush_sum;
  always_comb begin
    flush_sum = {1'b0, flushed_q} + 17'(count_q) + 17'(inflight_q);
    fetched_d = (pop && fetched_q != 16'hFFFF) ? fetched_q + 16'd1 : fetched_q;
    flushed_d = !jump ? flushed_q : flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
    end
  end
  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`endif
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch front end of the pipelined processor. It owns the program counter and issues word-addressed requests to instruction memory. Returned words go into a small prefetch queue that presents instructions to decode under a valid/ready handshake. It consumes the `jump_occured`/target redirect produced by the ALU stage, flushing all fetched and in-flight wrong-path words.

## Interface
Parameters:
- `DEPTH`, 4: prefetch queue entries (power of two, ≥2).
- `RESET_PC`, 16'h0000: PC value loaded on reset.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request this cycle.
- `imem_addr`  out  16  word address of the request (equals `pc`).
- `imem_rdata`  in  16  instruction word; valid exactly one cycle after a cycle with `imem_req`=1.
- `if_valid`  out  1  queue head holds a valid instruction.
- `if_instr`  out  16  queue head instruction.
- `if_pc`  out  16  address the head instruction was fetched from.
- `if_ready`  in  1  decode accepts the head; pop when `if_valid && if_ready`.
- `jump_occured`  in  1  redirect request from the ALU stage.
- `jump_target`  in  16  new PC; sampled when `jump_occured`=1.

## Operation
- State: `pc` (16b), queue of `DEPTH` entries {instr, pc}, read/write pointers, occupancy count, 1-bit `inflight` flag with its 16-bit address, 1-bit `squash` flag.
- Issue rule: `imem_req = (count + inflight < DEPTH) && !jump_occured`. Reserving a slot for the in-flight word makes overflow impossible.
- On each issue: `inflight` set, address captured, `pc <= pc + 1`. Wrap is mod 2^16, so 16'hFFFF goes to 16'h0000.
- Response: in the cycle after an issue, if `squash`=0, push {`imem_rdata`, captured address}. `inflight` clears unless a new request issues in the same cycle.
- Pop: on `if_valid && if_ready`, advance the read pointer. Push and pop in the same cycle leave `count` unchanged.
- Redirect (`jump_occured`=1 at a rising edge):
  - queue emptied;
  - `pc <= jump_target`;
  - no request issued that cycle;
  - if a request is outstanding, `squash` is set so its returning word is dropped.
  - `squash` clears on the following edge.
- A pop coinciding with a redirect is suppressed: `if_valid` is forced 0 while `jump_occured`=1.
- Back-to-back redirects: the later target wins. Each redirect cycle suppresses issue.
- `if_instr`/`if_pc` are don't-care when `if_valid`=0. In RTL they are driven from the head slot.

## Timing
- Reset values (asynchronous): `pc`=`RESET_PC`, count=0, `inflight`=0, `squash`=0, `imem_req`=0 during reset, `if_valid`=0, `if_instr`=0, `if_pc`=0.
- After reset release:
  - first rising edge with `imem_req`=1 carries `imem_addr`=`RESET_PC`;
  - `if_valid` rises after the following edge. Fetch-to-decode latency is 2 cycles.
- Throughput: 1 word/cycle sustained when `if_ready`=1 continuously.
- Redirect latency: the edge with `jump_occured` is followed by a request to `jump_target` in the next cycle. The target instruction is at the head 2 cycles after the redirect edge.
- Reset asserted mid-operation: all state is cleared immediately. A response returning after reset release is ignored, because `inflight`=0.

## Configuration
- `FETCH_PERF_CNT_EN`: when defined, adds two outputs:
  - `perf_fetched` (16b): increments per accepted pop;
  - `perf_flushed` (16b): increments by count + squashed in-flight words at each redirect.
  - Both saturate at 16'hFFFF and reset to 0.
- Without the macro, neither these ports nor their logic exist. Fetch behaviour is identical either way.

## Test plan
- Reset release, memory returns `addr ^ 16'hA5A5`, `if_ready`=1 -> requests 0,1,2,…; `if_pc`=0 on the cycle `if_valid` first rises, with `if_instr`=16'hA5A5; one instruction per cycle thereafter.
- `if_ready`=0 for 10 cycles -> `imem_req` drops once count+inflight=4; no word is lost or duplicated after `if_ready` returns.
- `jump_occured`=1, `jump_target`=16'h0040 while queue holds 3 words with 1 in flight -> `if_valid`=0 that cycle; next request addr 16'h0040; the squashed word is never presented; next `if_pc`=16'h0040.
- `RESET_PC`=16'hFFFE, free-running -> fetch addresses FFFE, FFFF, 0000, 0001.
- Redirect on two consecutive cycles to 16'h0010 then 16'h0020 -> first issued address 16'h0020; nothing from 16'h0010 reaches decode.
- `rst_n` pulsed low mid-stream with a request outstanding -> `if_valid`=0 immediately; fetch restarts at `RESET_PC`. With `FETCH_PERF_CNT_EN`, both counters read 0.
